// File: rtl/com_sw_to_fw_pkg.sv
// Shared definitions for the SW-to-FW command sequencer: opcode encoding,
// command-word and status-word field positions, and device-field decoding.
package com_sw_to_fw_pkg;

  typedef enum logic [3:0] {
    NOOP         = 4'h0,
    W_RST_FW     = 4'h1,
    W_CFG_FW     = 4'h2,
    W_PARAM_FW   = 4'h3,
    W_START_FW   = 4'h4,
    W_STOP_FW    = 4'h5,
    W_DATA_FW    = 4'h6,
    R_DATA_FW    = 4'h7,
    W_MODE_FW    = 4'h8,
    R_MODE_FW    = 4'h9,
    R_STATUS_FW  = 4'hA,
    W_EXECUTE    = 4'hB
  } op_code_e;

  // Highest opcode that is accepted; anything above raises err_op.
  localparam logic [3:0] OP_MAX = 4'hB;

  // Command word fields.
  localparam int DEV_HI  = 31;
  localparam int DEV_LO  = 28;
  localparam int OP_HI   = 27;
  localparam int OP_LO   = 24;
  localparam int BODY_HI = 23;
  localparam int BODY_LO = 0;

  // Controller status word fields.
  localparam int ST_CNT_LO   = 24;
  localparam int ST_DEV_LO   = 20;
  localparam int ST_OP_LO    = 16;
  localparam int ST_BUSY     = 15;
  localparam int ST_ERR_TMO  = 3;
  localparam int ST_ERR_BUSY = 2;
  localparam int ST_ERR_OP   = 1;
  localparam int ST_ERR_DEV  = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } dev_dec_t;

  // Map the 4-bit dev field to a FW index. One-hot mode: exactly one bit set
  // and inside the population. Binary mode: value k+1 selects FW k, 0 = none.
  function automatic dev_dec_t dev_decode(input logic [3:0] dev,
                                          input logic       onehot,
                                          input logic [4:0] num_fw);
    dev_dec_t r;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    if (onehot) begin
      case (dev)
        4'b0001: begin r.valid = 1'b1; r.idx = 4'd0; end
        4'b0010: begin r.valid = 1'b1; r.idx = 4'd1; end
        4'b0100: begin r.valid = 1'b1; r.idx = 4'd2; end
        4'b1000: begin r.valid = 1'b1; r.idx = 4'd3; end
        default: begin r.valid = 1'b0; r.idx = 4'd0; end
      endcase
      if ({1'b0, r.idx} >= num_fw) begin
        r.valid = 1'b0;
      end else begin
        r.valid = r.valid;
      end
    end else begin
      if ((dev != 4'd0) && ({1'b0, dev} <= num_fw)) begin
        r.valid = 1'b1;
        r.idx   = dev - 4'd1;
      end else begin
        r.valid = 1'b0;
        r.idx   = 4'd0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/com_busy_tracker.sv
// Per-FW busy flags with done handling and one shared timeout counter that
// times only the most recently loaded FW.
module com_busy_tracker
  import com_sw_to_fw_pkg::*;
#(
  parameter int unsigned NUM_FW         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [3:0]        set_idx,
  input  logic [NUM_FW-1:0] done,
  output logic [NUM_FW-1:0] busy,
  output logic              tmo_fire
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0]     tmo_cnt_r;
  logic [3:0]        tmo_idx_r;
  logic              tmo_busy_s;
  logic              tmo_done_s;
  logic              expire_s;
  logic [NUM_FW-1:0] busy_next_s;

  // Busy and done state of the FW currently owning the timer.
  always_comb begin
    tmo_busy_s = 1'b0;
    tmo_done_s = 1'b0;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      if (tmo_idx_r == 4'(i)) begin
        tmo_busy_s = busy[i];
        tmo_done_s = done[i];
      end else begin
        tmo_busy_s = tmo_busy_s;
        tmo_done_s = tmo_done_s;
      end
    end
  end

  // The timer expires on its last count unless the FW finished in the same cycle.
  assign expire_s = (tmo_cnt_r == TW'(1)) && tmo_busy_s && !tmo_done_s;
  assign tmo_fire = expire_s;

  // Done clears first, then a timeout clears, then a new busy command sets.
  always_comb begin
    busy_next_s = busy & ~done;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      if (expire_s && (tmo_idx_r == 4'(i))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_next_s[i];
      end
      if (set_valid && (set_idx == 4'(i))) begin
        busy_next_s[i] = 1'b1;
      end else begin
        busy_next_s[i] = busy_next_s[i];
      end
    end
  end

  // Busy vector and timeout counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      tmo_cnt_r <= '0;
      tmo_idx_r <= 4'd0;
    end else begin
      busy <= busy_next_s;
      if (set_valid && (TIMEOUT_CYCLES > 0)) begin
        tmo_cnt_r <= TW'(TIMEOUT_CYCLES);
        tmo_idx_r <= set_idx;
      end else if (tmo_cnt_r != '0) begin
        if (tmo_done_s || !tmo_busy_s) begin
          tmo_cnt_r <= '0;
        end else begin
          tmo_cnt_r <= tmo_cnt_r - TW'(1);
        end
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

endmodule

// File: rtl/com_sw_to_fw_seq.sv
// Registered SW-to-FW command sequencer: captures command words on a write
// strobe, decodes device and opcode, drives FW enables/strobes, tracks busy
// FWs and reports sticky errors plus muxed FW read data.
module com_sw_to_fw_seq
  import com_sw_to_fw_pkg::*;
#(
  parameter int unsigned NUM_FW         = 4,
  parameter int unsigned DEV_ONEHOT     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                   fw_axi_clk,
  input  logic                   fw_rst,
  input  logic [31:0]            sw_write32_0,
  input  logic                   sw_write32_0_wr,
  output logic [31:0]            sw_read32_0,
  output logic [31:0]            sw_read32_1,
  output logic [31:0]            sw_read32_2,
  output logic [NUM_FW-1:0]      fw_dev_id_enable,
  output logic [15:0]            fw_op_strobe,
  output logic [23:0]            sw_write24_0,
  input  logic [NUM_FW-1:0]      fw_done,
  input  logic [NUM_FW-1:0][31:0] fw_read_data32,
  input  logic [NUM_FW-1:0][31:0] fw_read_status32
);

  logic [3:0]        dev_s;
  logic [3:0]        op_s;
  logic [23:0]       body_s;
  dev_dec_t          dec_s;
  logic              busy_now_s;
  logic              busy_ok_op_s;
  logic              accept_s;
  logic              set_busy_s;
  logic              clr_err_s;
  logic              set_err_dev_s;
  logic              set_err_op_s;
  logic              set_err_busy_s;
  logic              tmo_fire_s;
  logic [NUM_FW-1:0] busy_s;
  logic [NUM_FW-1:0] en_onehot_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       rd_stat_s;
  logic [7:0]        cnt8_s;

  logic              sel_valid_r;
  logic [3:0]        sel_idx_r;
  logic [3:0]        last_dev_r;
  logic [3:0]        last_op_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              err_dev_r;
  logic              err_op_r;
  logic              err_busy_r;
  logic              err_tmo_r;

  assign dev_s  = sw_write32_0[DEV_HI:DEV_LO];
  assign op_s   = sw_write32_0[OP_HI:OP_LO];
  assign body_s = sw_write32_0[BODY_HI:BODY_LO];
  assign dec_s  = dev_decode(dev_s, DEV_ONEHOT != 0, 5'(NUM_FW));

  assign busy_ok_op_s = (op_s == R_STATUS_FW) || (op_s == W_RST_FW);

  // Busy state of the addressed FW after this cycle's done pulse is applied.
  always_comb begin
    busy_now_s  = 1'b0;
    en_onehot_s = '0;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      if (dec_s.idx == 4'(i)) begin
        busy_now_s     = busy_s[i] & ~fw_done[i];
        en_onehot_s[i] = 1'b1;
      end else begin
        busy_now_s     = busy_now_s;
        en_onehot_s[i] = 1'b0;
      end
    end
  end

  // Accept/reject decision and error raising for the current command.
  always_comb begin
    accept_s       = 1'b0;
    clr_err_s      = 1'b0;
    set_err_dev_s  = 1'b0;
    set_err_op_s   = 1'b0;
    set_err_busy_s = 1'b0;
    if (sw_write32_0_wr) begin
      if (op_s == NOOP) begin
        clr_err_s = body_s[0];
      end else begin
        set_err_op_s  = (op_s > OP_MAX);
        set_err_dev_s = !dec_s.valid;
        if (!(op_s > OP_MAX) && dec_s.valid) begin
          if (busy_now_s && !busy_ok_op_s) begin
            set_err_busy_s = 1'b1;
          end else begin
            accept_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  assign set_busy_s = accept_s && ((op_s == W_EXECUTE) || (op_s == W_RST_FW));

  com_busy_tracker #(
    .NUM_FW         (NUM_FW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_busy (
    .clk       (fw_axi_clk),
    .rst       (fw_rst),
    .set_valid (set_busy_s),
    .set_idx   (dec_s.idx),
    .done      (fw_done),
    .busy      (busy_s),
    .tmo_fire  (tmo_fire_s)
  );

  // Read-data mux over the currently selected FW; no selection reads zero.
  always_comb begin
    rd_data_s = 32'd0;
    rd_stat_s = 32'd0;
    for (int i = 0; i < int'(NUM_FW); i++) begin
      if (sel_valid_r && (sel_idx_r == 4'(i))) begin
        rd_data_s = fw_read_data32[i];
        rd_stat_s = fw_read_status32[i];
      end else begin
        rd_data_s = rd_data_s;
        rd_stat_s = rd_stat_s;
      end
    end
  end

  // Command capture, opcode strobe, counter, sticky errors and read registers.
  always_ff @(posedge fw_axi_clk) begin
    if (fw_rst) begin
      fw_dev_id_enable <= '0;
      fw_op_strobe     <= 16'd0;
      sw_write24_0     <= 24'd0;
      sel_valid_r      <= 1'b0;
      sel_idx_r        <= 4'd0;
      last_dev_r       <= 4'd0;
      last_op_r        <= 4'd0;
      cnt_r            <= '0;
      err_dev_r        <= 1'b0;
      err_op_r         <= 1'b0;
      err_busy_r       <= 1'b0;
      err_tmo_r        <= 1'b0;
      sw_read32_0      <= 32'd0;
      sw_read32_1      <= 32'd0;
    end else begin
      if (accept_s) begin
        fw_dev_id_enable <= en_onehot_s;
        fw_op_strobe     <= 16'd1 << op_s;
        sw_write24_0     <= body_s;
        sel_valid_r      <= 1'b1;
        sel_idx_r        <= dec_s.idx;
        last_dev_r       <= dec_s.idx;
        last_op_r        <= op_s;
        cnt_r            <= cnt_r + CNT_W'(1);
      end else begin
        fw_op_strobe     <= 16'd0;
      end
      err_dev_r   <= (clr_err_s ? 1'b0 : err_dev_r)  | set_err_dev_s;
      err_op_r    <= (clr_err_s ? 1'b0 : err_op_r)   | set_err_op_s;
      err_busy_r  <= (clr_err_s ? 1'b0 : err_busy_r) | set_err_busy_s;
      err_tmo_r   <= (clr_err_s ? 1'b0 : err_tmo_r)  | tmo_fire_s;
      sw_read32_0 <= rd_data_s;
      sw_read32_1 <= rd_stat_s;
    end
  end

  // Counter view in the status word: truncated or zero-extended to 8 bits.
  generate
    if (CNT_W >= 8) begin : g_cnt_trunc
      assign cnt8_s = cnt_r[7:0];
    end else begin : g_cnt_ext
      assign cnt8_s = {{(8 - CNT_W){1'b0}}, cnt_r};
    end
  endgenerate

  assign sw_read32_2 = {cnt8_s, last_dev_r, last_op_r, |busy_s, 11'd0,
                        err_tmo_r, err_busy_r, err_op_r, err_dev_r};

endmodule

// File: tb/tb_com_sw_to_fw_seq.sv
// Self-checking bench for com_sw_to_fw_seq: a one-hot 4-FW instance driven
// from a table through a scoreboard queue, plus a binary 8-FW instance and
// hand-written reset/timeout sequences.
module tb_com_sw_to_fw_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // One-hot, 4 FW, short timeout instance
  logic [31:0]      cmd;
  logic             wr;
  logic [3:0]       done;
  logic [3:0][31:0] rdat;
  logic [3:0][31:0] rsts;
  logic [31:0]      rd0, rd1, stat;
  logic [3:0]       en;
  logic [15:0]      strb;
  logic [23:0]      body;

  // Binary, 8 FW, timeout disabled instance
  logic [31:0]      cmd_b;
  logic             wr_b;
  logic [7:0]       done_b;
  logic [7:0][31:0] rdat_b;
  logic [7:0][31:0] rsts_b;
  logic [31:0]      rd0_b, rd1_b, stat_b;
  logic [7:0]       en_b;
  logic [15:0]      strb_b;
  logic [23:0]      body_b;

  int checks = 0;
  int errors = 0;

  com_sw_to_fw_seq #(.NUM_FW(4), .DEV_ONEHOT(1), .TIMEOUT_CYCLES(10), .CNT_W(8)) dut (
    .fw_axi_clk(clk), .fw_rst(rst), .sw_write32_0(cmd), .sw_write32_0_wr(wr),
    .sw_read32_0(rd0), .sw_read32_1(rd1), .sw_read32_2(stat),
    .fw_dev_id_enable(en), .fw_op_strobe(strb), .sw_write24_0(body),
    .fw_done(done), .fw_read_data32(rdat), .fw_read_status32(rsts));

  com_sw_to_fw_seq #(.NUM_FW(8), .DEV_ONEHOT(0), .TIMEOUT_CYCLES(0), .CNT_W(8)) dut_b (
    .fw_axi_clk(clk), .fw_rst(rst), .sw_write32_0(cmd_b), .sw_write32_0_wr(wr_b),
    .sw_read32_0(rd0_b), .sw_read32_1(rd1_b), .sw_read32_2(stat_b),
    .fw_dev_id_enable(en_b), .fw_op_strobe(strb_b), .sw_write24_0(body_b),
    .fw_done(done_b), .fw_read_data32(rdat_b), .fw_read_status32(rsts_b));

  typedef struct {
    logic [31:0] cmd;
    logic        wr;
    logic [3:0]  done;
    logic [3:0]  en;
    logic [15:0] strb;
    logic [23:0] body;
    logic [31:0] stat;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected status word from its fields.
  function automatic logic [31:0] st(input int c, input int d, input int o,
                                     input bit b, input logic [3:0] e);
    return {8'(c), 4'(d), 4'(o), b, 11'd0, e};
  endfunction

  function automatic void add(input logic [31:0] c, input logic w, input logic [3:0] dn,
                              input logic [3:0] e, input logic [15:0] s, input logic [23:0] bd,
                              input logic [31:0] sw, input int rsel);
    vec_t v;
    v.cmd = c; v.wr = w; v.done = dn; v.en = e; v.strb = s; v.body = bd; v.stat = sw;
    v.rd0 = (rsel < 0) ? 32'd0 : 32'hD000_0000 + 32'(rsel);
    v.rd1 = (rsel < 0) ? 32'd0 : 32'h5000_0000 + 32'(rsel);
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; cmd = 32'd0; wr = 1'b0; done = 4'd0;
    cmd_b = 32'd0; wr_b = 1'b0; done_b = 8'd0;
    for (int i = 0; i < 4; i++) begin
      rdat[i] = 32'hD000_0000 + 32'(i);
      rsts[i] = 32'h5000_0000 + 32'(i);
    end
    for (int i = 0; i < 8; i++) begin
      rdat_b[i] = 32'hD000_0000 + 32'(i);
      rsts_b[i] = 32'h5000_0000 + 32'(i);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check32("rst_en", 32'(en), 32'd0);
    check32("rst_strb", 32'(strb), 32'd0);
    check32("rst_body", 32'(body), 32'd0);
    check32("rst_stat", stat, 32'd0);
    check32("rst_rd0", rd0, 32'd0);
    check32("rst_rd1", rd1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Command table: expected outputs after the clock edge that samples the row.
    add(32'h1B00_0005, 1'b1, 4'd0, 4'b0001, 16'h0800, 24'h5, st(1, 0, 11, 1'b1, 4'b0000), -1);
    add(32'h1400_0000, 1'b1, 4'd0, 4'b0001, 16'h0000, 24'h5, st(1, 0, 11, 1'b1, 4'b0100), 0);
    add(32'h0000_0000, 1'b0, 4'b0001, 4'b0001, 16'h0000, 24'h5, st(1, 0, 11, 1'b0, 4'b0100), 0);
    add(32'h1400_0000, 1'b1, 4'd0, 4'b0001, 16'h0010, 24'h0, st(2, 0, 4, 1'b0, 4'b0100), 0);
    add(32'h3B00_0000, 1'b1, 4'd0, 4'b0001, 16'h0000, 24'h0, st(2, 0, 4, 1'b0, 4'b0101), 0);
    add(32'h2C00_0000, 1'b1, 4'd0, 4'b0001, 16'h0000, 24'h0, st(2, 0, 4, 1'b0, 4'b0111), 0);
    add(32'h0000_0001, 1'b1, 4'd0, 4'b0001, 16'h0000, 24'h0, st(2, 0, 4, 1'b0, 4'b0000), 0);
    add(32'h2B00_0000, 1'b1, 4'd0, 4'b0010, 16'h0800, 24'h0, st(3, 1, 11, 1'b1, 4'b0000), 0);
    for (int i = 0; i < 9; i++)
      add(32'h0, 1'b0, 4'd0, 4'b0010, 16'h0000, 24'h0, st(3, 1, 11, 1'b1, 4'b0000), 1);
    add(32'h0000_0000, 1'b0, 4'd0, 4'b0010, 16'h0000, 24'h0, st(3, 1, 11, 1'b0, 4'b1000), 1);
    add(32'h0000_0000, 1'b0, 4'b0110, 4'b0010, 16'h0000, 24'h0, st(3, 1, 11, 1'b0, 4'b1000), 1);
    add(32'hF000_0000, 1'b1, 4'd0, 4'b0010, 16'h0000, 24'h0, st(3, 1, 11, 1'b0, 4'b1000), 1);
    add(32'h4B00_0000, 1'b1, 4'd0, 4'b0100, 16'h0800, 24'h0, st(4, 2, 11, 1'b1, 4'b1000), 1);
    add(32'h4B00_0007, 1'b1, 4'b0100, 4'b0100, 16'h0800, 24'h7, st(5, 2, 11, 1'b1, 4'b1000), 2);
    add(32'h4A00_0000, 1'b1, 4'd0, 4'b0100, 16'h0400, 24'h0, st(6, 2, 10, 1'b1, 4'b1000), 2);
    add(32'h4100_0000, 1'b1, 4'd0, 4'b0100, 16'h0002, 24'h0, st(7, 2, 1, 1'b1, 4'b1000), 2);
    add(32'h4500_0000, 1'b1, 4'd0, 4'b0100, 16'h0000, 24'h0, st(7, 2, 1, 1'b1, 4'b1100), 2);
    add(32'h8B00_0003, 1'b1, 4'd0, 4'b1000, 16'h0800, 24'h3, st(8, 3, 11, 1'b1, 4'b1100), 2);
    add(32'h0000_0001, 1'b1, 4'd0, 4'b1000, 16'h0000, 24'h3, st(8, 3, 11, 1'b1, 4'b0000), 3);
    add(32'h0000_0000, 1'b0, 4'b1000, 4'b1000, 16'h0000, 24'h3, st(8, 3, 11, 1'b1, 4'b0000), 3);
    add(32'h0000_0000, 1'b0, 4'b0100, 4'b1000, 16'h0000, 24'h3, st(8, 3, 11, 1'b0, 4'b0000), 3);
    for (int j = 1; j <= 248; j++)
      add(32'h1A00_0000, 1'b1, 4'd0, 4'b0001, 16'h0400, 24'h0,
          st((8 + j) % 256, 0, 10, 1'b0, 4'b0000), (j == 1) ? 3 : 0);
    add(32'h0000_0000, 1'b0, 4'd0, 4'b0001, 16'h0000, 24'h0, st(0, 0, 10, 1'b0, 4'b0000), 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      cmd = tbl[i].cmd; wr = tbl[i].wr; done = tbl[i].done;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      v = sb.pop_front();
      check32($sformatf("row%0d_en", i), 32'(en), 32'(v.en));
      check32($sformatf("row%0d_strb", i), 32'(strb), 32'(v.strb));
      check32($sformatf("row%0d_body", i), 32'(body), 32'(v.body));
      check32($sformatf("row%0d_stat", i), stat, v.stat);
      check32($sformatf("row%0d_rd0", i), rd0, v.rd0);
      check32($sformatf("row%0d_rd1", i), rd1, v.rd1);
    end

    // Reset while a FW is busy aborts everything, including the timer.
    @(negedge clk);
    cmd = 32'h1B00_0000; wr = 1'b1; done = 4'd0;
    @(posedge clk); #1;
    check32("busy_before_rst", stat, st(1, 0, 11, 1'b1, 4'b0000));
    @(negedge clk);
    wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check32("midrst_en", 32'(en), 32'd0);
    check32("midrst_strb", 32'(strb), 32'd0);
    check32("midrst_body", 32'(body), 32'd0);
    check32("midrst_stat", stat, 32'd0);
    check32("midrst_rd0", rd0, 32'd0);
    check32("midrst_rd1", rd1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check32("post_rst_no_tmo", stat, 32'd0);

    // Binary decode, 8 FW, timeout disabled.
    @(negedge clk);
    cmd_b = 32'h8A00_0000; wr_b = 1'b1;
    @(posedge clk); #1;
    check32("bin_en7", 32'(en_b), 32'h80);
    check32("bin_strb", 32'(strb_b), 32'h0400);
    check32("bin_stat", stat_b, st(1, 7, 10, 1'b0, 4'b0000));
    @(negedge clk);
    wr_b = 1'b0;
    @(posedge clk); #1;
    check32("bin_strb_low", 32'(strb_b), 32'h0);
    check32("bin_rd0", rd0_b, 32'hD000_0007);
    check32("bin_rd1", rd1_b, 32'h5000_0007);
    @(negedge clk);
    cmd_b = 32'h9A00_0000; wr_b = 1'b1;
    @(posedge clk); #1;
    check32("bin_dev9_err", stat_b, st(1, 7, 10, 1'b0, 4'b0001));
    check32("bin_dev9_en", 32'(en_b), 32'h80);
    check32("bin_dev9_strb", 32'(strb_b), 32'h0);
    @(negedge clk);
    cmd_b = 32'h0000_0001;
    @(posedge clk); #1;
    check32("bin_clear", stat_b, st(1, 7, 10, 1'b0, 4'b0000));
    @(negedge clk);
    cmd_b = 32'h0A00_0000;
    @(posedge clk); #1;
    check32("bin_dev0_err", stat_b, st(1, 7, 10, 1'b0, 4'b0001));
    @(negedge clk);
    cmd_b = 32'h1B00_0000;
    @(posedge clk); #1;
    check32("bin_exec", stat_b, st(2, 0, 11, 1'b1, 4'b0001));
    check32("bin_exec_en", 32'(en_b), 32'h01);
    @(negedge clk);
    wr_b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check32("bin_no_timeout", stat_b, st(2, 0, 11, 1'b1, 4'b0001));
    @(negedge clk);
    done_b = 8'h01;
    @(posedge clk); #1;
    check32("bin_done", stat_b, st(2, 0, 11, 1'b0, 4'b0001));
    @(negedge clk);
    done_b = 8'h00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
